slow_clock_ctrl: RTL and testbench

//  Parametrised slow-clock generator for the board top: divides the 50 MHz board clock to a runtime-selectable

---
 rtl/slow_clock_pkg.sv | 22 ++
 rtl/slow_clock_ctrl_key_debounce.sv | 40 ++++
 rtl/slow_clock_ctrl.sv | 166 ++++++++++++++++
 tb/tb_slow_clock_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slow_clock_pkg.sv
// Shared types and helpers for the slow-clock generator.
// Holds the mode encoding and the per-rate divisor rule.
package slow_clock_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        PAUSED     = 2'd1,
        STEP       = 2'd2,
        PAUSE_PEND = 2'd3
    } mode_t;

    function automatic int unsigned div_for_rate(
        input int unsigned div0,
        input int unsigned shift,
        input int unsigned k
    );
        int unsigned d;
        d = div0 >> (shift * k);
        return (d < 2) ? 2 : d;
    endfunction

endpackage

// File: rtl/slow_clock_ctrl_key_debounce.sv
// Key conditioner: 2-flop synchroniser plus stability counter.
// level only follows the key after DEBOUNCE_CYCLES identical samples.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level
);

    localparam int unsigned CW =
        (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                cnt   <= '0;
                level <= sync2;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/slow_clock_ctrl.sv
// Board slow-clock generator with run/pause and single-step keys.
// Define CYCLE_COUNT_EN to build the cycle_count tick counter.
module slow_clock_ctrl
    import slow_clock_pkg::*;
#(
    parameter int unsigned DIV0            = 100_000_000,
    parameter int unsigned NRATES          = 4,
    parameter int unsigned RATE_SHIFT      = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned NCOUNT          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [$clog2(NRATES)-1:0] rate_sel,
    input  logic                      key_run_n,
    input  logic                      key_step_n,
    output logic                      clk_slow,
    output logic                      tick,
    output mode_t                     mode,
    output logic [NCOUNT-1:0]         cycle_count
);

    localparam int unsigned DW = $clog2(DIV0 + 1);

    logic [DW-1:0] count;
    logic [DW-1:0] count_adv;
    logic [DW-1:0] count_next;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_eff;
    logic [DW-1:0] rate_div;
    logic [DW-1:0] hi;
    logic          fresh;
    logic          wrap;
    logic          clk_adv;
    logic          clk_next;
    logic          fall;
    logic          adv;
    logic          park;
    mode_t         mode_next;
    int unsigned   rate_k;

    logic run_level;
    logic step_level;
    logic run_prev;
    logic step_prev;
    logic run_press;
    logic step_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_run_n),
        .level (run_level)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_key (
        .clk   (clk),
        .reset (reset),
        .key_n (key_step_n),
        .level (step_level)
    );

    assign run_press  = run_prev & ~run_level;
    assign step_press = step_prev & ~step_level;

    // Until the first edge after reset the live rate_sel sets the divisor.
    always_comb begin
        rate_k = (32'(rate_sel) >= NRATES) ? NRATES - 1 : 32'(rate_sel);
        rate_div = DW'(div_for_rate(DIV0, RATE_SHIFT, rate_k));
        div_eff = fresh ? rate_div : div_q;
        hi = div_eff - (div_eff >> 1);
        wrap = (count == div_eff - DW'(1));
        count_adv = wrap ? '0 : count + DW'(1);
        clk_adv = (count < hi);
        fall = clk_slow & ~clk_adv;
    end

    // adv steps the divider; park forces count=0 and a low output.
    always_comb begin
        mode_next = mode;
        adv       = 1'b0;
        park      = 1'b0;
        unique case (mode)
            RUN: begin
                if (run_press && !clk_slow) begin
                    mode_next = PAUSED;
                    park      = 1'b1;
                end else begin
                    adv = 1'b1;
                    if (run_press) begin
                        if (fall) begin
                            mode_next = PAUSED;
                            park      = 1'b1;
                        end else begin
                            mode_next = PAUSE_PEND;
                        end
                    end
                end
            end
            PAUSE_PEND: begin
                adv = 1'b1;
                if (run_press) begin
                    mode_next = RUN;
                end else if (fall) begin
                    mode_next = PAUSED;
                    park      = 1'b1;
                end
            end
            PAUSED: begin
                park = 1'b1;
                if (run_press) begin
                    mode_next = RUN;
                end else if (step_press) begin
                    mode_next = STEP;
                end
            end
            STEP: begin
                adv = 1'b1;
                if (wrap) begin
                    mode_next = PAUSED;
                    park      = 1'b1;
                end
            end
            default: mode_next = RUN;
        endcase
        count_next = park ? '0 : (adv ? count_adv : count);
        clk_next   = adv ? clk_adv : (park ? 1'b0 : clk_slow);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            div_q     <= DW'(2);
            fresh     <= 1'b1;
            clk_slow  <= 1'b0;
            tick      <= 1'b0;
            mode      <= RUN;
            run_prev  <= 1'b1;
            step_prev <= 1'b1;
        end else begin
            fresh     <= 1'b0;
            if (fresh || (adv && wrap)) begin
                div_q <= rate_div;
            end
            count     <= count_next;
            clk_slow  <= clk_next;
            tick      <= clk_next & ~clk_slow;
            mode      <= mode_next;
            run_prev  <= run_level;
            step_prev <= step_level;
        end
    end

`ifdef CYCLE_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_count <= '0;
        end else if (clk_next && !clk_slow) begin
            cycle_count <= cycle_count + NCOUNT'(1);
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_slow_clock_ctrl.sv
// Bench for slow_clock_ctrl: directed scenarios then random keys,
// rates and resets, all checked against a behavioural model.
module tb_slow_clock_ctrl;

    localparam int M_RUN    = 0;
    localparam int M_PAUSED = 1;
    localparam int M_STEP   = 2;
    localparam int M_PEND   = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  rate_sel = 2'd0;
    logic        key_run_n = 1'b1;
    logic        key_step_n = 1'b1;
    logic        clk_slow;
    logic        tick;
    logic [1:0]  mode;
    logic [15:0] cycle_count;

    int checks = 0;
    int failures = 0;

    slow_clock_ctrl #(
        .DIV0            (8),
        .NRATES          (4),
        .RATE_SHIFT      (1),
        .DEBOUNCE_CYCLES (4),
        .NCOUNT          (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rate_sel    (rate_sel),
        .key_run_n   (key_run_n),
        .key_step_n  (key_step_n),
        .clk_slow    (clk_slow),
        .tick        (tick),
        .mode        (mode),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    // Reference model state: pos is the period index of the next edge.
    int m_pos, m_div, m_mode, m_cc;
    bit m_clk, m_tick, m_fresh;
    bit rq[6];
    bit sq[6];
    bit r_lvl, s_lvl, r_pend, s_pend;

    function automatic int divisor(input int k);
        int kk;
        int d;
        kk = (k > 3) ? 3 : k;
        d = 8 >> kk;
        return (d < 2) ? 2 : d;
    endfunction

    function automatic bit settled_other(input bit q[6], input bit lvl);
        for (int i = 2; i < 6; i++)
            if (q[i] == lvl) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_cc();
`ifdef CYCLE_COUNT_EN
        return m_cc;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_pos = 0; m_div = 2; m_mode = M_RUN; m_cc = 0;
        m_clk = 0; m_tick = 0; m_fresh = 1;
        for (int i = 0; i < 6; i++) begin
            rq[i] = 1'b1;
            sq[i] = 1'b1;
        end
        r_lvl = 1; s_lvl = 1; r_pend = 0; s_pend = 0;
    endtask

    task automatic model_edge();
        bit pr, ps, prev, nclk, falls, wrapping, adv;
        int hi, npos;
        if (!reset) return;
        pr = r_pend;
        ps = s_pend;
        for (int i = 5; i > 0; i--) begin
            rq[i] = rq[i-1];
            sq[i] = sq[i-1];
        end
        rq[0] = key_run_n;
        sq[0] = key_step_n;
        r_pend = 0;
        if (settled_other(rq, r_lvl)) begin
            r_pend = r_lvl;
            r_lvl = !r_lvl;
        end
        s_pend = 0;
        if (settled_other(sq, s_lvl)) begin
            s_pend = s_lvl;
            s_lvl = !s_lvl;
        end
        if (m_fresh) begin
            m_div = divisor(int'(rate_sel));
            m_fresh = 0;
        end
        hi = m_div - m_div / 2;
        prev = m_clk;
        wrapping = (m_pos == m_div - 1);
        nclk = (m_pos < hi);
        npos = wrapping ? 0 : m_pos + 1;
        falls = m_clk && !nclk;
        adv = 0;
        case (m_mode)
            M_RUN: begin
                if (pr && !m_clk) m_mode = M_PAUSED;
                else begin
                    adv = 1;
                    if (pr) m_mode = falls ? M_PAUSED : M_PEND;
                end
            end
            M_PEND: begin
                adv = 1;
                if (pr) m_mode = M_RUN;
                else if (falls) m_mode = M_PAUSED;
            end
            M_PAUSED: begin
                if (pr) m_mode = M_RUN;
                else if (ps) m_mode = M_STEP;
            end
            default: begin
                adv = 1;
                if (wrapping) m_mode = M_PAUSED;
            end
        endcase
        if (adv) begin
            m_clk = nclk;
            m_pos = npos;
            if (wrapping) m_div = divisor(int'(rate_sel));
        end
        if (m_mode == M_PAUSED) begin
            m_pos = 0;
            m_clk = 0;
        end
        m_tick = m_clk && !prev;
        if (m_tick) m_cc = (m_cc + 1) % 65536;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        failures++;
        $error("FAIL %s wait bound expired", tag);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_slow", 32'(clk_slow), 32'(m_clk));
        chk("tick", 32'(tick), 32'(m_tick));
        chk("mode", 32'(mode), m_mode);
        chk("cycle_count", 32'(cycle_count), exp_cc());
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clk"}, 32'(clk_slow), 0);
        chk({tag, "_tick"}, 32'(tick), 0);
        chk({tag, "_mode"}, 32'(mode), M_RUN);
        chk({tag, "_cc"}, 32'(cycle_count), 0);
    endtask

    // Async assert mid-cycle, hold for a few edges, release away from edge.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_zero(tag);
        cycn(3);
        reset = 1'b1;
    endtask

    task automatic press_run(input int n);
        key_run_n = 1'b0;
        cycn(n);
        key_run_n = 1'b1;
    endtask

    task automatic press_step(input int n);
        key_step_n = 1'b0;
        cycn(n);
        key_step_n = 1'b1;
    endtask

    initial begin
        int n;
        int nt;
        logic [31:0] cc_before;
        int r;

        model_reset();
        cycn(3);
        check_zero("reset");
        reset = 1'b1;

        // 1: free run at rate 0
        cyc();
        chk("first_rise", 32'(clk_slow), 1);
        chk("first_tick", 32'(tick), 1);
        cycn(23);
`ifdef CYCLE_COUNT_EN
        chk("cc_24", 32'(cycle_count), 3);
`else
        chk("cc_24", 32'(cycle_count), 0);
`endif

        // 2: rate change mid-period, then clamp
        n = 0;
        while (m_pos != 2 && n < 16) begin cyc(); n++; end
        if (m_pos != 2) timeout("pos2");
        rate_sel = 2'd2;
        cycn(20);
        rate_sel = 2'd3;
        cycn(12);
        rate_sel = 2'd0;
        cycn(16);

        // 3: run press lands in the high phase
        n = 0;
        while (m_pos != 4 && n < 20) begin cyc(); n++; end
        if (m_pos != 4) timeout("pos4");
        press_run(6);
        cycn(12);
        chk("pause_reached", 32'(mode), M_PAUSED);
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("paused_tick", 32'(tick), 0);
            chk("paused_clk", 32'(clk_slow), 0);
        end

        // 4: single step with a long-held key
        cc_before = exp_cc();
        nt = 0;
        key_step_n = 1'b0;
        for (int i = 0; i < 10; i++) begin cyc(); nt += int'(tick); end
        key_step_n = 1'b1;
        for (int i = 0; i < 30; i++) begin cyc(); nt += int'(tick); end
        chk("step_ticks", nt, 1);
`ifdef CYCLE_COUNT_EN
        chk("step_cc", 32'(cycle_count), (cc_before + 1) % 65536);
`else
        chk("step_cc", 32'(cycle_count), cc_before);
`endif
        chk("step_done", 32'(mode), M_PAUSED);

        // 5: bounce, then same-cycle run and step presses
        for (int i = 0; i < 10; i++) begin
            key_run_n = ~key_run_n;
            cycn(2);
        end
        key_run_n = 1'b1;
        cycn(10);
        chk("bounce_mode", 32'(mode), M_PAUSED);
        key_run_n = 1'b0;
        key_step_n = 1'b0;
        cycn(6);
        key_run_n = 1'b1;
        key_step_n = 1'b1;
        cycn(12);
        chk("run_wins", 32'(mode), M_RUN);

        // 6: reset during STEP at count 5
        press_run(6);
        n = 0;
        while (m_mode != M_PAUSED && n < 30) begin cyc(); n++; end
        if (m_mode != M_PAUSED) timeout("to_paused");
        press_step(6);
        n = 0;
        while (!(m_mode == M_STEP && m_pos == 5) && n < 30) begin
            cyc();
            n++;
        end
        if (!(m_mode == M_STEP && m_pos == 5)) timeout("step_pos5");
        pulse_reset("step_rst");
        cycn(24);
`ifdef CYCLE_COUNT_EN
        chk("cc_after_rst", 32'(cycle_count), 3);
`else
        chk("cc_after_rst", 32'(cycle_count), 0);
`endif

        // random phase
        for (int it = 0; it < 1200; it++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) begin
                rate_sel = 2'($urandom_range(0, 3));
                cyc();
            end else if (r < 6) begin
                press_run(int'($urandom_range(1, 9)));
            end else if (r < 9) begin
                press_step(int'($urandom_range(1, 9)));
            end else if (r < 10) begin
                pulse_reset("rand_rst");
            end else begin
                cyc();
            end
        end
        cycn(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
